vdp_vram_read_arbiter: RTL and testbench
========================================

// Module: vdp_vram_read_arbiter
// PURPOSE
// - Shares the single VRAM read port between three requesters: layer fetch (L), sprite render (S), host/copper (H).
// - Sits between vdp_sprite_core's vram_read_address/vram_data_valid pair, the layer fetch unit and the host read path.
// - Fixed priority for L; round-robin between S and H; starvation guard for H.
// - Tags each issued read so that the data-valid strobe returns only to the requester that issued it.
// PARAMETERS
// - READ_LATENCY    2   cycles from vram_address/vram_read_en registered out to vram_read_data valid (1..4)
// - HOST_MAX_WAIT   15  H waiting cycles after which H beats S (4-bit counter, saturating)
// PORTS
// - clk            in   1   system clock
// - reset          in   1   synchronous, active-high reset
// - l_req          in   1   layer fetch read request, held with l_addr until l_grant
// - l_addr         in   14  layer fetch VRAM word address
// - l_grant        out  1   combinational grant to L this cycle
// - l_valid        out  1   vram_read_data belongs to L this cycle
// - s_req/s_addr/s_grant/s_valid   in/in/out/out  1/14/1/1   same for sprite render
// - h_req/h_addr/h_grant/h_valid   in/in/out/out  1/14/1/1   same for host/copper
// - vram_address   out  14  registered address to VRAM
// - vram_read_en   out  1   registered read strobe to VRAM
// - vram_read_data in   32  VRAM read data, broadcast unchanged to all requesters
// BEHAVIOUR
// - Reset:
//   - all grants/valids 0; vram_read_en 0; vram_address 0.
//   - RR pointer = S; H wait counter 0; tag pipeline cleared.
// - Arbitration (combinational, cycle N):
//   - l_req -> L.
//   - else h_req & wait==HOST_MAX_WAIT -> H.
//   - else s_req & h_req -> side named by RR pointer.
//   - else the single requester.
//   - At most one grant per cycle; grant never asserted without matching req.
// - RR pointer flips to the other of S/H only when S or H is granted; unchanged on an L grant or an idle cycle.
// - H wait counter:
//   - +1 (saturating at 15) each cycle h_req & !h_grant.
//   - cleared on h_grant or when !h_req.
// - Issue: on any grant at N, vram_address <= granted addr and vram_read_en <= 1 at N+1; otherwise vram_read_en <= 0 and vram_address holds.
// - Return:
//   - 2-bit tag (00 none, 01 L, 10 S, 11 H) shifts through a READ_LATENCY+1 stage pipeline.
//   - Matching *_valid pulses for exactly 1 cycle at N+1+READ_LATENCY.
//   - Valids are mutually exclusive.
// - Throughput: one read per cycle back-to-back; pipeline never stalls; requester may re-request the cycle after grant.
// - Requester rule: req/addr stable until grant; dropping req before grant is legal and cancels nothing in flight.
// - Reset mid-operation: in-flight tags discarded; no *_valid in the READ_LATENCY+1 cycles after reset deasserts unless newly issued.
// - Simultaneous grant and return in the same cycle are independent.
// TESTING
// - Reset then idle -> all grants/valids 0, vram_read_en 0 for 10 cycles.
// - Single S request, s_addr=14'h1234, READ_LATENCY=2 -> s_grant at N, vram_address=1234/read_en at N+1, s_valid at N+3 only.
// - l_req,s_req,h_req all held high for 20 cycles -> l_grant every cycle, s/h_grant never, wait counter saturates at 15.
// - s_req,h_req held, l_req low -> grants alternate S,H,S,H...; valids alternate 3 cycles later, no gaps.
// - L held 8 cycles then released with s_req/h_req held, wait=15 -> first post-L grant goes to H regardless of RR pointer.
// - Issue 3 reads (L,S,H) back-to-back, assert reset at cycle 2 -> no *_valid after reset; first post-reset grant follows reset RR (S).

Source files
------------

// File: rtl/vdp_vram_read_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vdp_vram_read_arbiter_if
// Brief    : Request/grant/valid bundle for the three VRAM read requesters
//            (layer fetch L, sprite render S, host/copper H) plus the VRAM
//            read port itself.
// Revision : 1.0 - initial release
// ============================================================================
interface vdp_vram_read_arbiter_if;
  // Layer fetch requester
  logic        l_req;
  logic [13:0] l_addr;
  logic        l_grant;
  logic        l_valid;
  // Sprite render requester
  logic        s_req;
  logic [13:0] s_addr;
  logic        s_grant;
  logic        s_valid;
  // Host/copper requester
  logic        h_req;
  logic [13:0] h_addr;
  logic        h_grant;
  logic        h_valid;
  // VRAM read port and the data broadcast back to every requester
  logic [13:0] vram_address;
  logic        vram_read_en;
  logic [31:0] vram_read_data;
  logic [31:0] read_data;

  // Arbiter side
  modport slave (
    input  l_req, l_addr, s_req, s_addr, h_req, h_addr, vram_read_data,
    output l_grant, l_valid, s_grant, s_valid, h_grant, h_valid,
    output vram_address, vram_read_en, read_data
  );

  // Requester / VRAM side
  modport master (
    output l_req, l_addr, s_req, s_addr, h_req, h_addr, vram_read_data,
    input  l_grant, l_valid, s_grant, s_valid, h_grant, h_valid,
    input  vram_address, vram_read_en, read_data
  );
endinterface
`default_nettype wire

// File: rtl/vdp_vram_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vdp_vram_read_arbiter
// Brief    : Shares the single VRAM read port between layer fetch (fixed top
//            priority), sprite render and host/copper (round-robin with a
//            host starvation guard). Each issued read is tagged so its
//            data-valid strobe returns only to the issuing requester.
// Revision : 1.0 - initial release
// ============================================================================
module vdp_vram_read_arbiter #(
  parameter int READ_LATENCY  = 2,   // 1..4 cycles from issue to read data
  parameter int HOST_MAX_WAIT = 15   // H wait cycles after which H beats S
) (
  input  logic                    clk,
  input  logic                    reset,
  vdp_vram_read_arbiter_if.slave  bus
);

  localparam logic [1:0] c_tag_none = 2'b00;
  localparam logic [1:0] c_tag_l    = 2'b01;
  localparam logic [1:0] c_tag_s    = 2'b10;
  localparam logic [1:0] c_tag_h    = 2'b11;
  localparam logic       c_rr_s     = 1'b0;
  localparam logic       c_rr_h     = 1'b1;
  localparam logic [3:0] c_wait_max = 4'd15;
  localparam logic [3:0] c_wait_thr = 4'(HOST_MAX_WAIT);
  localparam int         c_pipe_w   = 2 * (READ_LATENCY + 1);

  logic                r_rr_ptr;     // side that wins the next S/H tie
  logic [3:0]          r_wait;       // cycles H has been held off
  logic [c_pipe_w-1:0] r_tag_pipe;   // stage k lives at [2k+1:2k]
  logic [13:0]         r_vram_address;
  logic                r_vram_read_en;

  logic       w_grant_l;
  logic       w_grant_s;
  logic       w_grant_h;
  logic       w_h_starved;
  logic [1:0] w_issue_tag;
  logic [1:0] w_ret_tag;
  logic [13:0] w_grant_addr;

  // Grant selection: L first, then a starved H, then the RR side, else whoever asks.
  always_comb begin
    w_grant_l   = 1'b0;
    w_grant_s   = 1'b0;
    w_grant_h   = 1'b0;
    w_h_starved = (r_wait >= c_wait_thr);
    if (!reset) begin
      if (bus.l_req) begin
        w_grant_l = 1'b1;
      end else if (bus.h_req && (w_h_starved || !bus.s_req || r_rr_ptr == c_rr_h)) begin
        w_grant_h = 1'b1;
      end else if (bus.s_req) begin
        w_grant_s = 1'b1;
      end
    end
  end

  // Tag and address of whatever was granted this cycle.
  always_comb begin
    w_issue_tag  = c_tag_none;
    w_grant_addr = bus.l_addr;
    if (w_grant_l) begin
      w_issue_tag  = c_tag_l;
      w_grant_addr = bus.l_addr;
    end else if (w_grant_s) begin
      w_issue_tag  = c_tag_s;
      w_grant_addr = bus.s_addr;
    end else if (w_grant_h) begin
      w_issue_tag  = c_tag_h;
      w_grant_addr = bus.h_addr;
    end
  end

  // RR pointer moves to the side that was not just served; L grants leave it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= c_rr_s;
    end else if (w_grant_s) begin
      r_rr_ptr <= c_rr_h;
    end else if (w_grant_h) begin
      r_rr_ptr <= c_rr_s;
    end
  end

  // H wait counter: counts held-off cycles, saturates, clears on grant or withdrawal.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait <= 4'd0;
    end else if (bus.h_req && !w_grant_h) begin
      if (r_wait != c_wait_max) begin
        r_wait <= r_wait + 4'd1;
      end
    end else begin
      r_wait <= 4'd0;
    end
  end

  // Issue register: address holds between reads, strobe is one cycle per grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vram_address <= 14'd0;
      r_vram_read_en <= 1'b0;
    end else begin
      r_vram_read_en <= (w_issue_tag != c_tag_none);
      if (w_issue_tag != c_tag_none) begin
        r_vram_address <= w_grant_addr;
      end
    end
  end

  // Tag pipeline: tag enters at the grant edge and emerges READ_LATENCY cycles after issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_pipe <= '0;
    end else begin
      r_tag_pipe <= {r_tag_pipe[c_pipe_w-3:0], w_issue_tag};
    end
  end

  assign w_ret_tag = r_tag_pipe[c_pipe_w-1 -: 2];

  assign bus.l_grant      = w_grant_l;
  assign bus.s_grant      = w_grant_s;
  assign bus.h_grant      = w_grant_h;
  assign bus.l_valid      = !reset && (w_ret_tag == c_tag_l);
  assign bus.s_valid      = !reset && (w_ret_tag == c_tag_s);
  assign bus.h_valid      = !reset && (w_ret_tag == c_tag_h);
  assign bus.vram_address = r_vram_address;
  assign bus.vram_read_en = r_vram_read_en;
  assign bus.read_data    = bus.vram_read_data;

endmodule
`default_nettype wire

// File: tb/tb_vdp_vram_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vdp_vram_read_arbiter
// Brief    : Self-checking bench for vdp_vram_read_arbiter. Directed scenarios
//            followed by randomized traffic, every cycle compared against a
//            rule-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vdp_vram_read_arbiter;

  localparam int RL = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Reference model state (requester ids: 0 none, 1 L, 2 S, 3 H)
  bit          known = 1'b0;
  bit          m_rr_h = 1'b0;
  int          m_wait = 0;
  bit          m_en = 1'b0;
  logic [13:0] m_addr = 14'd0;
  int          exp_tag [int];

  vdp_vram_read_arbiter_if bus ();

  vdp_vram_read_arbiter #(
    .READ_LATENCY  (RL),
    .HOST_MAX_WAIT (15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic int expect_grant(input logic rs, input logic lq, input logic sq, input logic hq);
    if (rs) return 0;
    if (lq) return 1;
    if (hq && m_wait >= 15) return 3;
    if (sq && hq) return m_rr_h ? 3 : 2;
    if (sq) return 2;
    if (hq) return 3;
    return 0;
  endfunction

  // One clock cycle: apply inputs, check at mid-cycle, advance model at the edge.
  task automatic step(input logic rs, input logic lq, input logic sq, input logic hq);
    int g;
    int et;
    logic [13:0] ga;
    reset              = rs;
    bus.l_req          = lq;
    bus.s_req          = sq;
    bus.h_req          = hq;
    bus.vram_read_data = $urandom;
    #1;
    g = expect_grant(rs, lq, sq, hq);
    chk("l_grant", {31'd0, bus.l_grant}, {31'd0, g == 1});
    chk("s_grant", {31'd0, bus.s_grant}, {31'd0, g == 2});
    chk("h_grant", {31'd0, bus.h_grant}, {31'd0, g == 3});
    chk("read_data", bus.read_data, bus.vram_read_data);
    if (known || rs) begin
      et = exp_tag.exists(cyc) ? exp_tag[cyc] : 0;
      if (rs) et = 0;
      chk("l_valid", {31'd0, bus.l_valid}, {31'd0, et == 1});
      chk("s_valid", {31'd0, bus.s_valid}, {31'd0, et == 2});
      chk("h_valid", {31'd0, bus.h_valid}, {31'd0, et == 3});
    end
    if (known) begin
      chk("vram_read_en", {31'd0, bus.vram_read_en}, {31'd0, m_en});
      chk("vram_address", {18'd0, bus.vram_address}, {18'd0, m_addr});
    end
    ga = (g == 1) ? bus.l_addr : (g == 2) ? bus.s_addr : bus.h_addr;
    @(posedge clk);
    if (rs) begin
      known  = 1'b1;
      m_rr_h = 1'b0;
      m_wait = 0;
      m_en   = 1'b0;
      m_addr = 14'd0;
      exp_tag.delete();
    end else begin
      if (g == 2) m_rr_h = 1'b1;
      if (g == 3) m_rr_h = 1'b0;
      m_wait = (hq && g != 3) ? ((m_wait < 15) ? m_wait + 1 : 15) : 0;
      m_en   = (g != 0);
      if (g != 0) begin
        m_addr = ga;
        exp_tag[cyc + 1 + RL] = g;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    bus.l_req = 1'b0; bus.s_req = 1'b0; bus.h_req = 1'b0;
    bus.l_addr = 14'h0111; bus.s_addr = 14'h0222; bus.h_addr = 14'h0333;
    bus.vram_read_data = 32'd0;
    @(negedge clk);

    // Reset, then idle
    repeat (3) step(1, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0);

    // Single S request at 0x1234, then watch the return
    bus.s_addr = 14'h1234;
    step(0, 0, 1, 0);
    repeat (5) step(0, 0, 0, 0);

    // All three held: L always wins, H wait saturates
    repeat (20) step(0, 1, 1, 1);
    // L released: starved H must win first, then S/H alternate
    repeat (10) step(0, 0, 1, 1);
    repeat (4) step(0, 0, 0, 0);

    // L held 8 cycles with S/H pending, then released
    repeat (8) step(0, 1, 1, 1);
    repeat (6) step(0, 0, 1, 1);
    repeat (4) step(0, 0, 0, 0);

    // L,S,H back-to-back with reset landing on the H cycle
    bus.l_addr = 14'h0aaa; bus.s_addr = 14'h0bbb; bus.h_addr = 14'h0ccc;
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(1, 0, 0, 1);
    repeat (5) step(0, 0, 0, 0);
    step(0, 0, 1, 1);
    repeat (4) step(0, 0, 0, 0);

    // Randomized traffic: moderate L load, then heavy L load to provoke starvation
    for (int i = 0; i < 600; i++) begin
      bus.l_addr = 14'($urandom);
      bus.s_addr = 14'($urandom);
      bus.h_addr = 14'($urandom);
      if (i < 300)
        step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 3),
             ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6));
      else
        step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) < 17),
             ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 8));
    end
    repeat (6) step(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
